muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, sitting beside the EX-stage ALU of the five-stage pipeline. It accepts MULT, MULTU, DIV and DIVU from ID/EX, runs for a fixed number of cycles, and writes the 2×XLEN product, or the quotient and remainder, into HI/LO. While it is busy, it asserts a stall request to the hazard logic. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- XLEN, 32, operand width; must be even and ≥ 8.
- MUL_STEP, 1, multiplier bits retired per cycle; must be 1, 2 or 4 and divide XLEN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  issue the operation on op_i.
- op_i  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- data1_i  in  XLEN  rs operand (multiplicand / dividend).
- data2_i  in  XLEN  rt operand (multiplier / divisor).
- mthi_i  in  1  write data1_i to HI.
- mtlo_i  in  1  write data1_i to LO.
- mf_req_i  in  1  an MFHI/MFLO is in ID/EX.
- flush_i  in  1  abort the operation in flight.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle pulse when HI/LO update with a result.
- dz_o  out  1  divide-by-zero; valid only with done_o.
- stall_o  out  1  stall request to the hazard unit.
- hi_o  out  XLEN  HI register.
- lo_o  out  XLEN  LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIXUP.
- IDLE:
  - start_i with op 0/1 → MUL; with op 2/3 → DIV.
  - Operand magnitudes are latched. For signed ops, the absolute values are latched plus the result-sign flags: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
- MUL: shift-add, retiring MUL_STEP bits per cycle into a 2×XLEN accumulator. Runs XLEN/MUL_STEP cycles, then → FIXUP.
- DIV: restoring division, one quotient bit per cycle. Runs XLEN cycles, then → FIXUP.
- FIXUP:
  - Applies two's-complement negation per the sign flags.
  - Writes HI/LO:
    - multiply: HI = upper half, LO = lower half;
    - divide: LO = quotient, HI = remainder.
  - Pulses done_o, then → IDLE.
- Divide by zero: no iteration shortcut. The result is LO = all-ones and HI = the original data1_i (raw, not the magnitude). dz_o = 1 with done_o.
- Signed overflow (−2^(XLEN−1) / −1): handled naturally by the unsigned-magnitude path. LO = −2^(XLEN−1), HI = 0.
- mthi_i/mtlo_i are honoured only in IDLE, and update the register at the next edge.
- If mthi_i/mtlo_i and start_i coincide in IDLE, start wins and the move is dropped. The pipeline never issues both.
- Requests made while busy are ignored, not queued:
  - start_i, mthi_i, mtlo_i, mf_req_i all raise stall_o.
  - stall_o = busy_o & (start_i | mf_req_i | mthi_i | mtlo_i), combinational.
- flush_i: any state → IDLE at the next edge. HI/LO are unchanged and there is no done_o. flush_i beats a simultaneous start_i in IDLE.

## Timing
- Reset values: state IDLE, hi_o = lo_o = 0, busy_o = done_o = dz_o = stall_o = 0 (stall_o is 0 with busy_o low).
- Cycle numbering: start_i is sampled at edge 0; busy_o = 1 after edge 0.
- Multiply: iteration edges 1..XLEN/MUL_STEP; FIXUP at edge XLEN/MUL_STEP+1. With defaults, done_o is high in the cycle after edge 33.
- Divide: FIXUP at edge XLEN+1. With defaults, done_o is high after edge 33.
- Signed and unsigned ops have identical latency.
- At the FIXUP edge, busy_o falls in the same cycle that done_o rises and hi_o/lo_o take their new values.
- A start_i in the done_o cycle is accepted, so back-to-back issue is possible.
- Reset asserted mid-operation: immediate return to IDLE with HI/LO cleared.

## Structure
- Package muldiv_pkg holds:
  - op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (S_IDLE, S_MUL, S_DIV, S_FIXUP);
  - the iteration-count function of XLEN and MUL_STEP.
- One sub-module, muldiv_negate: a parametrised conditional two's-complement (width, enable), instantiated for the operand abs step and for the FIXUP sign step.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → done after 33 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU of the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 / 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 100 / 7 → LO = 14, HI = 2.
- DIVU 0x1234 / 0 → LO = 0xFFFFFFFF, HI = 0x1234, dz_o = 1 during done_o. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- mf_req_i held from cycle 5 of a MULT → stall_o = 1 until the done_o cycle, then 0. mthi_i while busy → HI unchanged, stall_o = 1.
- flush_i at cycle 10 of a DIV → IDLE next edge, no done_o, HI/LO keep their prior values. A new MULTU issued next cycle completes normally.
- rst_i low mid-MULT → busy_o, hi_o and lo_o are 0 immediately. Rerun with MUL_STEP = 4: 0xFFFF × 0xFFFF → LO = 0xFFFE0001, done after 9 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_e;

    function automatic int iter_count(input int xlen, input int step);
        return xlen / step;
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: y = en ? -a : a.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and stall request.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    input  logic            mf_req_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            dz_o,
    output logic            stall_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    import muldiv_pkg::*;

    localparam int N_MUL = iter_count(XLEN, MUL_STEP);
    localparam int N_DIV = XLEN;
    localparam int CW    = $clog2(XLEN + 1);
    localparam int AW    = 2 * XLEN;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   raw1_q, raw1_d;
    logic              div_q, div_d;
    logic              psign_q, psign_d;
    logic              rsign_q, rsign_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    op_e               op_w;
    logic              is_div;
    logic              is_sgn;
    logic [XLEN-1:0]   abs1, abs2;
    logic [AW-1:0]     prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign op_w   = op_e'(op_i);
    assign is_div = (op_w == OP_DIV) | (op_w == OP_DIVU);
    assign is_sgn = (op_w == OP_MULT) | (op_w == OP_DIV);

    muldiv_negate #(.W(XLEN)) u_abs1 (
        .en (is_sgn & data1_i[XLEN-1]),
        .a  (data1_i),
        .y  (abs1)
    );

    muldiv_negate #(.W(XLEN)) u_abs2 (
        .en (is_sgn & data2_i[XLEN-1]),
        .a  (data2_i),
        .y  (abs2)
    );

    muldiv_negate #(.W(AW)) u_prod_fix (
        .en (psign_q),
        .a  (acc_q),
        .y  (prod_fix)
    );

    muldiv_negate #(.W(XLEN)) u_quo_fix (
        .en (psign_q),
        .a  (acc_q[XLEN-1:0]),
        .y  (quo_fix)
    );

    muldiv_negate #(.W(XLEN)) u_rem_fix (
        .en (rsign_q),
        .a  (acc_q[AW-1:XLEN]),
        .y  (rem_fix)
    );

    // Multiply: acc = {partial high, remaining multiplier bits}.
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [AW-1:0]            mul_next;

    assign mul_sum  = {{MUL_STEP{1'b0}}, acc_q[AW-1:XLEN]}
                    + ({{MUL_STEP{1'b0}}, b_q}
                       * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]});
    assign mul_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};

    // Divide: acc = {remainder, dividend/quotient shift register}.
    logic [XLEN:0]   div_trial;
    logic [AW-1:0]   div_next;

    assign div_trial = {acc_q[AW-1:XLEN], acc_q[XLEN-1]} - {1'b0, b_q};
    assign div_next  = div_trial[XLEN]
                     ? {acc_q[AW-2:0], 1'b0}
                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        raw1_d  = raw1_q;
        div_d   = div_q;
        psign_d = psign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = is_div ? S_DIV : S_MUL;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, is_div ? abs1 : abs2};
                    b_d     = is_div ? abs2 : abs1;
                    raw1_d  = data1_i;
                    div_d   = is_div;
                    psign_d = is_sgn & (data1_i[XLEN-1] ^ data2_i[XLEN-1]);
                    rsign_d = is_sgn & data1_i[XLEN-1];
                end else begin
                    if (mthi_i) hi_d = data1_i;
                    if (mtlo_i) lo_d = data1_i;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_MUL - 1)) state_d = S_FIXUP;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_DIV - 1)) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    hi_d = prod_fix[AW-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end else if (b_q == '0) begin
                    hi_d = raw1_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dz_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            raw1_q  <= '0;
            div_q   <= 1'b0;
            psign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            raw1_q  <= raw1_d;
            div_q   <= div_d;
            psign_q <= psign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign dz_o    = dz_q;
    assign stall_o = busy_o & (start_i | mf_req_i | mthi_i | mtlo_i);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random ops against an arithmetic model.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, mthi_i, mtlo_i, mf_req_i, flush_i;
    logic [1:0]  op_i;
    logic [31:0] data1_i, data2_i;
    logic        busy_o, done_o, dz_o, stall_o;
    logic [31:0] hi_o, lo_o;
    logic        busy4, done4, dz4, stall4;
    logic [31:0] hi4, lo4;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .data1_i(data1_i), .data2_i(data2_i), .mthi_i(mthi_i),
        .mtlo_i(mtlo_i), .mf_req_i(mf_req_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o),
        .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .data1_i(data1_i), .data2_i(data2_i), .mthi_i(mthi_i),
        .mtlo_i(mtlo_i), .mf_req_i(mf_req_i), .flush_i(flush_i),
        .busy_o(busy4), .done_o(done4), .dz_o(dz4),
        .stall_o(stall4), .hi_o(hi4), .lo_o(lo4)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a, b,
                                  output logic [31:0] hi, lo,
                                  output logic dz);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        p  = '0;
        if (op < 2) begin
            if (op == 0) p = 64'(sa * sb);
            else         p = {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            dz = 1'b1;
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == 2) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Called at a negedge; issues op and waits for both units to finish.
    // mode: 0 plain, 1 mf_req held from cycle 5, 2 mthi while busy.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        logic [31:0] ehi, elo, h1, l1, h4, l4, prior_hi;
        logic        edz, d1, d4;
        int          lat1, lat4;
        model(op, a, b, ehi, elo, edz);
        prior_hi = hi_o;
        h1 = 'x; l1 = 'x; h4 = 'x; l4 = 'x; d1 = 'x; d4 = 'x;
        start_i = 1'b1; op_i = op; data1_i = a; data2_i = b;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        check({tag, "_busy"}, 64'(busy_o), 64'(1));
        lat1 = -1;
        lat4 = -1;
        for (int c = 1; c <= 40 && lat1 < 0; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (done4 && lat4 < 0) begin
                lat4 = c; h4 = hi4; l4 = lo4; d4 = dz4;
            end
            if (done_o) begin
                lat1 = c; h1 = hi_o; l1 = lo_o; d1 = dz_o;
            end
            if (mode == 1 && c == 4) mf_req_i = 1'b1;
            if (mode == 1 && c >= 5)
                check({tag, "_stall_mf"}, 64'(stall_o), 64'(!done_o));
            if (mode == 2 && c == 7) begin
                check({tag, "_hi_kept"}, 64'(hi_o), 64'(prior_hi));
                mthi_i = 1'b0;
            end
            if (mode == 2 && c == 6) begin
                mthi_i = 1'b1;
                data1_i = 32'hDEAD_BEEF;
                #1;
                check({tag, "_stall_mthi"}, 64'(stall_o), 64'(1));
            end
        end
        mf_req_i = 1'b0;
        mthi_i = 1'b0;
        check({tag, "_lat"}, 64'(lat1), 64'(33));
        check({tag, "_hi"}, 64'(h1), 64'(ehi));
        check({tag, "_lo"}, 64'(l1), 64'(elo));
        check({tag, "_dz"}, 64'(d1), 64'(edz));
        check({tag, "_busy_done"}, 64'(busy_o), 64'(0));
        check({tag, "_lat4"}, 64'(lat4), 64'(op < 2 ? 9 : 33));
        check({tag, "_hi4"}, 64'(h4), 64'(ehi));
        check({tag, "_lo4"}, 64'(l4), 64'(elo));
        check({tag, "_dz4"}, 64'(d4), 64'(edz));
    endtask

    initial begin
        logic [31:0] ph, pl, ra, rb;
        logic [1:0]  rop;
        int          ndone;
        rst_i = 1'b0;
        start_i = 0; mthi_i = 0; mtlo_i = 0; mf_req_i = 0; flush_i = 0;
        op_i = 0; data1_i = 0; data2_i = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_hi", 64'(hi_o), 64'(0));
        check("rst_lo", 64'(lo_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_dz", 64'(dz_o), 64'(0));
        check("rst_stall", 64'(stall_o), 64'(0));
        rst_i = 1'b1;
        @(negedge clk_i);

        mthi_i = 1'b1; data1_i = 32'h0000_A5A5;
        @(negedge clk_i);
        mthi_i = 1'b0; mtlo_i = 1'b1; data1_i = 32'h0000_5A5A;
        @(negedge clk_i);
        mtlo_i = 1'b0;
        check("mthi_idle", 64'(hi_o), 64'h0000_A5A5);
        check("mtlo_idle", 64'(lo_o), 64'h0000_5A5A);

        run_op("mult_m1x2", 2'd0, 32'hFFFF_FFFF, 32'h2, 0);
        run_op("multu_m1x2", 2'd1, 32'hFFFF_FFFF, 32'h2, 0);
        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'h2, 0);
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 0);
        run_op("divu_dz", 2'd3, 32'h1234, 32'h0, 0);
        run_op("div_dz_neg", 2'd2, 32'hFFFF_FFF9, 32'h0, 0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("multu_ffff", 2'd1, 32'h0000_FFFF, 32'h0000_FFFF, 0);
        run_op("mult_mf", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_op("multu_mthi", 2'd1, 32'h0BAD_F00D, 32'h0000_1003, 2);

        // Back-to-back random ops, each issued in the prior done cycle.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            run_op("rand", rop, ra, rb, 0);
        end

        // Flush a DIV in cycle 10.
        ph = hi_o;
        pl = lo_o;
        start_i = 1'b1; op_i = 2'd2; data1_i = 32'd1000; data2_i = 32'd3;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'(0));
        check("flush_busy4", 64'(busy4), 64'(0));
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (done_o || done4) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'(0));
        check("flush_hi", 64'(hi_o), 64'(ph));
        check("flush_lo", 64'(lo_o), 64'(pl));
        run_op("multu_after_flush", 2'd1, 32'hCAFE_0001, 32'h0000_0100, 0);

        // Flush beats start in IDLE.
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'd0;
        data1_i = 32'd5; data2_i = 32'd6;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_vs_start", 64'(busy_o), 64'(0));

        // Reset mid-MULT.
        start_i = 1'b1; op_i = 2'd0; data1_i = 32'd77; data2_i = 32'd88;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_hi", 64'(hi_o), 64'(0));
        check("midrst_lo", 64'(lo_o), 64'(0));
        check("midrst_busy4", 64'(busy4), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (done_o || busy_o) ndone++;
        end
        check("midrst_quiet", 64'(ndone), 64'(0));
        run_op("multu_ffff_final", 2'd1, 32'h0000_FFFF, 32'h0000_FFFF, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
